// File: rtl/seq_code_monitor.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | seq_code_monitor: checks the synchronised 0-2-4-7 ripple code, locks, counts errors |
// | Optional SEQ_MON_GLITCH_FILTER_EN: accept only STABLE_CYCLES-stable samples. Rev 1.0 |
// +------------------------------------------------------------------------------+
module seq_code_monitor #(
   parameter int LOCK_CNT      = 4,
   parameter int ERR_W         = 8,
   parameter int STABLE_CYCLES = 2
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [2:0]       code_i,
   input  logic             clr_i,
   output logic [2:0]       code_o,
   output logic [2:0]       exp_code_o,
   output logic [1:0]       step_o,
   output logic             locked_o,
   output logic             err_o,
   output logic [ERR_W-1:0] err_cnt_o
);

   localparam logic [1:0] SEARCH = 2'd0;
   localparam logic [1:0] CHECK  = 2'd1;
   localparam logic [1:0] LOCKED = 2'd2;

   localparam int                GOOD_W   = $clog2(LOCK_CNT + 1);
   localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_CNT);
   localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

   function automatic logic is_legal(input logic [2:0] c);
      return (c == 3'd0) || (c == 3'd2) || (c == 3'd4) || (c == 3'd7);
   endfunction

   function automatic logic [2:0] succ_of(input logic [2:0] c);
      logic [2:0] s;
      case (c)
         3'd0:    s = 3'd2;
         3'd2:    s = 3'd4;
         3'd4:    s = 3'd7;
         default: s = 3'd0;
      endcase
      return s;
   endfunction

   function automatic logic [1:0] step_of(input logic [2:0] c);
      logic [1:0] s;
      case (c)
         3'd2:    s = 2'd1;
         3'd4:    s = 2'd2;
         3'd7:    s = 2'd3;
         default: s = 2'd0;
      endcase
      return s;
   endfunction

   logic [2:0]        sync1_q, sync2_q;
   logic [2:0]        code_q, code_d;
   logic [1:0]        state_q, state_d;
   logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
   logic              acc_vld_q, acc_vld_d;
   logic              err_q, err_d;
   logic              locked_q, locked_d;
   logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
   logic              sample_stable;
   logic              acc_event;

`ifdef SEQ_MON_GLITCH_FILTER_EN
   localparam int              STAB_W   = $clog2(STABLE_CYCLES + 1);
   localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);

   // Counts edges that sync2 has held its current value, the loading edge counting as one.
   logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;

   always_comb begin
      stab_cnt_d = stab_cnt_q;
      if (sync1_q != sync2_q) begin
         stab_cnt_d = STAB_W'(1);
      end else if (stab_cnt_q != STAB_MAX) begin
         stab_cnt_d = stab_cnt_q + STAB_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         stab_cnt_q <= '0;
      end else begin
         stab_cnt_q <= stab_cnt_d;
      end
   end

   assign sample_stable = (stab_cnt_q == STAB_MAX);
`else
   assign sample_stable = 1'b1;
`endif

   assign acc_event = sample_stable && (!acc_vld_q || (sync2_q != code_q));

   always_comb begin
      state_d    = state_q;
      good_cnt_d = good_cnt_q;
      code_d     = code_q;
      acc_vld_d  = acc_vld_q;
      err_d      = 1'b0;
      if (acc_event) begin
         code_d    = sync2_q;
         acc_vld_d = 1'b1;
         case (state_q)
            SEARCH: begin
               if (is_legal(sync2_q)) begin
                  state_d    = CHECK;
                  good_cnt_d = '0;
               end
            end
            CHECK, LOCKED: begin
               if (sync2_q == succ_of(code_q)) begin
                  if (state_q == CHECK) begin
                     good_cnt_d = good_cnt_q + GOOD_W'(1);
                     if (good_cnt_d == GOOD_MAX) begin
                        state_d = LOCKED;
                     end
                  end
               end else begin
                  err_d      = 1'b1;
                  good_cnt_d = '0;
                  if (is_legal(sync2_q)) begin
                     state_d = CHECK;
                  end else begin
                     // Dropping to SEARCH re-arms the unconditional first-sample accept.
                     state_d   = SEARCH;
                     acc_vld_d = 1'b0;
                  end
               end
            end
            default: begin
               state_d   = SEARCH;
               acc_vld_d = 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (clr_i) begin
         err_cnt_d = err_d ? ERR_W'(1) : '0;
      end else if (err_d && (err_cnt_q != ERR_MAX)) begin
         err_cnt_d = err_cnt_q + ERR_W'(1);
      end
   end

   assign locked_d = (state_d == LOCKED);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         code_q     <= '0;
         state_q    <= SEARCH;
         good_cnt_q <= '0;
         acc_vld_q  <= 1'b0;
         err_q      <= 1'b0;
         locked_q   <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         sync1_q    <= code_i;
         sync2_q    <= sync1_q;
         code_q     <= code_d;
         state_q    <= state_d;
         good_cnt_q <= good_cnt_d;
         acc_vld_q  <= acc_vld_d;
         err_q      <= err_d;
         locked_q   <= locked_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign code_o     = code_q;
   assign exp_code_o = (state_q == SEARCH) ? 3'd0 : succ_of(code_q);
   assign step_o     = step_of(code_q);
   assign locked_o   = locked_q;
   assign err_o      = err_q;
   assign err_cnt_o  = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_code_monitor.sv
`default_nettype none
// tb_seq_code_monitor: directed vectors against hand-computed expectations.
module tb_seq_code_monitor;

   localparam int LOCK_CNT = 4;
   localparam int ERR_W    = 2;
`ifdef SEQ_MON_GLITCH_FILTER_EN
   localparam int LAT  = 4;
   localparam int FILT = 1;
`else
   localparam int LAT  = 3;
   localparam int FILT = 0;
`endif

   logic             clk   = 1'b0;
   logic             rst_n = 1'b1;
   logic             clr   = 1'b0;
   logic [2:0]       code_in = 3'd0;
   logic [2:0]       code_o, exp_code_o;
   logic [1:0]       step_o;
   logic             locked_o, err_o;
   logic [ERR_W-1:0] err_cnt_o;

   int n_checks = 0;
   int n_errors = 0;

   seq_code_monitor #(
      .LOCK_CNT      (LOCK_CNT),
      .ERR_W         (ERR_W),
      .STABLE_CYCLES (2)
   ) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .code_i     (code_in),
      .clr_i      (clr),
      .code_o     (code_o),
      .exp_code_o (exp_code_o),
      .step_o     (step_o),
      .locked_o   (locked_o),
      .err_o      (err_o),
      .err_cnt_o  (err_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic hold(input logic [2:0] c, input int n);
      code_in = c;
      wait_neg(n);
   endtask

   logic [2:0] viol_code [5] = '{3'd4, 3'd2, 3'd0, 3'd7, 3'd2};
   int         viol_cnt  [5] = '{1, 2, 3, 3, 3};

   initial begin
      #1 rst_n = 1'b0;
      wait_neg(2);
      check_val("rst_code",   int'(code_o),     0);
      check_val("rst_exp",    int'(exp_code_o), 0);
      check_val("rst_step",   int'(step_o),     0);
      check_val("rst_locked", int'(locked_o),   0);
      check_val("rst_err",    int'(err_o),      0);
      check_val("rst_cnt",    int'(err_cnt_o),  0);
      rst_n = 1'b1;

      // Clean acquisition and lock
      hold(3'd0, 8);
      check_val("acq0_code", int'(code_o),     0);
      check_val("acq0_exp",  int'(exp_code_o), 2);
      check_val("acq0_lock", int'(locked_o),   0);
      hold(3'd2, 8);
      check_val("acq2_step", int'(step_o),     1);
      check_val("acq2_exp",  int'(exp_code_o), 4);
      hold(3'd4, 8);
      check_val("acq4_step", int'(step_o),     2);
      hold(3'd7, 8);
      check_val("acq7_step", int'(step_o),     3);
      check_val("acq7_lock", int'(locked_o),   0);
      hold(3'd0, LAT - 1);
      check_val("prelock_code", int'(code_o),   7);
      check_val("prelock_lock", int'(locked_o), 0);
      wait_neg(1);
      check_val("lock_code", int'(code_o),   0);
      check_val("lock_lock", int'(locked_o), 1);
      check_val("lock_step", int'(step_o),   0);
      wait_neg(6);
      check_val("acq_cnt", int'(err_cnt_o), 0);

      // Skip 2 -> 7 while locked
      hold(3'd2, 8);
      check_val("l2_lock", int'(locked_o), 1);
      hold(3'd7, LAT);
      check_val("skip_err",  int'(err_o),      1);
      check_val("skip_cnt",  int'(err_cnt_o),  1);
      check_val("skip_lock", int'(locked_o),   0);
      check_val("skip_exp",  int'(exp_code_o), 0);
      check_val("skip_code", int'(code_o),     7);
      wait_neg(1);
      check_val("skip_pulse", int'(err_o), 0);
      hold(3'd7, 6);
      hold(3'd0, 8);
      check_val("resync_exp",  int'(exp_code_o), 2);
      check_val("resync_cnt",  int'(err_cnt_o),  1);
      check_val("resync_lock", int'(locked_o),   0);

      // Illegal code drops to SEARCH; illegal codes in SEARCH are silent
      hold(3'd3, 8);
      check_val("ill3_cnt",  int'(err_cnt_o),  2);
      check_val("ill3_exp",  int'(exp_code_o), 0);
      check_val("ill3_code", int'(code_o),     3);
      hold(3'd5, 8);
      check_val("srch5_cnt",  int'(err_cnt_o), 2);
      check_val("srch5_code", int'(code_o),    5);
      hold(3'd4, 8);
      check_val("srch4_exp",  int'(exp_code_o), 7);
      check_val("srch4_step", int'(step_o),     2);
      check_val("srch4_cnt",  int'(err_cnt_o),  2);
      hold(3'd3, LAT);
      check_val("chk3_err", int'(err_o),      1);
      check_val("chk3_cnt", int'(err_cnt_o),  3);
      check_val("chk3_exp", int'(exp_code_o), 0);
      wait_neg(7);

      // Saturation of a 2-bit counter and clear/error collision
      clr = 1'b1;
      wait_neg(1);
      clr = 1'b0;
      check_val("clr_cnt", int'(err_cnt_o), 0);
      hold(3'd0, 8);
      check_val("sat_start_exp", int'(exp_code_o), 2);
      for (int i = 0; i < 5; i++) begin
         hold(viol_code[i], 8);
         check_val($sformatf("sat_cnt%0d", i), int'(err_cnt_o), viol_cnt[i]);
      end
      code_in = 3'd0;
      wait_neg(LAT - 1);
      clr = 1'b1;
      wait_neg(1);
      clr = 1'b0;
      check_val("clr_err_pulse", int'(err_o),     1);
      check_val("clr_err_cnt",   int'(err_cnt_o), 1);
      wait_neg(7);

      // Ripple intermediate 2 -> 0 -> 4
      clr = 1'b1;
      wait_neg(1);
      clr = 1'b0;
      hold(3'd2, 8);
      check_val("gl_pre_code", int'(code_o),    2);
      check_val("gl_pre_cnt",  int'(err_cnt_o), 0);
      hold(3'd0, 1);
      hold(3'd4, 2);
      check_val("gl_mid_code", int'(code_o), (FILT != 0) ? 2 : 0);
      hold(3'd4, 6);
      check_val("gl_code", int'(code_o),    4);
      check_val("gl_cnt",  int'(err_cnt_o), (FILT != 0) ? 0 : 2);

      // Relock, then asynchronous reset mid-hold and reacquire
      hold(3'd7, 8);
      hold(3'd0, 8);
      hold(3'd2, 8);
      hold(3'd4, 8);
      check_val("relock", int'(locked_o), 1);
      hold(3'd7, 4);
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_lock", int'(locked_o),  0);
      check_val("arst_code", int'(code_o),    0);
      check_val("arst_cnt",  int'(err_cnt_o), 0);
      check_val("arst_err",  int'(err_o),     0);
      code_in = 3'd0;
      wait_neg(2);
      rst_n = 1'b1;
      hold(3'd0, 8);
      check_val("post_exp", int'(exp_code_o), 2);
      hold(3'd2, 8);
      hold(3'd4, 8);
      hold(3'd7, 8);
      check_val("post7_lock", int'(locked_o), 0);
      hold(3'd0, 8);
      check_val("post_lock", int'(locked_o),  1);
      check_val("post_cnt",  int'(err_cnt_o), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seq_code_monitor.md
# seq_code_monitor

Synchronous monitor for the 3-bit 0→2→4→7→0 code produced by the ripple sequence counter. It samples the counter output through a two-flop synchroniser and accepts code changes. It checks each accepted change against the legal successor, asserts lock after a run of legal steps, and reports violations as a pulse plus a saturating count. It sits in the consuming clock domain, between the counter and status/CSR logic.

## Interface
- `LOCK_CNT`, 4: consecutive legal transitions required to assert lock (1..15)
- `ERR_W`, 8: width of the error counter
- `STABLE_CYCLES`, 2: synchronised-sample stability depth (used only with the filter macro, ≥2)

- `clk_i`  in  1  clock, rising edge
- `rst_n_i`  in  1  asynchronous active-low reset
- `code_i`  in  3  counter code, asynchronous to `clk_i`
- `clr_i`  in  1  synchronous clear of `err_cnt_o`
- `code_o`  out  3  last accepted code
- `exp_code_o`  out  3  expected next code (valid when `state != SEARCH`)
- `step_o`  out  2  index of `code_o` in sequence: 0→0, 2→1, 4→2, 7→3
- `locked_o`  out  1  sequence locked
- `err_o`  out  1  one-cycle pulse per violation
- `err_cnt_o`  out  ERR_W  saturating violation count

## Operation
- Synchroniser: `sync1`, `sync2` on `code_i`. Both reset to 0.
- Accept event:
  - First sample after reset, or after any return to SEARCH, is always an event (`acc_vld` = 0).
  - After that, an event is `sync2 != code_o`.
  - On an event, `code_o` ← `sync2`.
- Legal codes: 0, 2, 4, 7. Successor: 0→2, 2→4, 4→7, 7→0. Codes 1, 3, 5, 6 are illegal.
- FSM states: SEARCH, CHECK, LOCKED. Reset state is SEARCH.
  - SEARCH:
    - Event with a legal code → CHECK, `good_cnt` = 0.
    - Event with an illegal code → stay in SEARCH, no error.
  - CHECK:
    - Event equal to `exp_code_o` → `good_cnt`++. When `good_cnt` reaches LOCK_CNT → LOCKED.
    - Any other event → `err_o` pulse and error count.
      - New code legal → resync: stay in CHECK, `good_cnt` = 0.
      - New code illegal → SEARCH.
  - LOCKED:
    - Event equal to expected → stay in LOCKED.
    - Mismatch → `err_o` pulse, `locked_o` drops, same resync/SEARCH rule as CHECK.
- `exp_code_o` = successor(`code_o`). Holds 0 in SEARCH.
- `err_cnt_o`:
  - Increments per error and saturates at 2^ERR_W−1.
  - `clr_i` alone → 0.
  - `clr_i` together with an error → 1.
- `locked_o` = (state == LOCKED), registered.

## Timing
- Reset values:
  - `code_o` = 0, `exp_code_o` = 0, `step_o` = 0.
  - `locked_o` = 0, `err_o` = 0, `err_cnt_o` = 0.
  - State is SEARCH, `acc_vld` = 0.
- Reset mid-operation clears everything immediately (asynchronous). Acquisition restarts on the first post-reset sample.
- Latency without the filter: `code_i` is stable before edge k. `sync2` updates at k+1. `code_o`, `err_o`, state and `locked_o` update at k+2.
- Latency with the filter: the accept moves to edge k+1+STABLE_CYCLES.
- `err_o` is high for exactly one cycle per event. Back-to-back events can pulse on consecutive cycles.
- Lock timing: `locked_o` rises on the same edge that accepts the LOCK_CNT-th legal transition.

## Configuration
- `SEQ_MON_GLITCH_FILTER_EN` defined:
  - An event is taken only once `sync2` has held the same value for STABLE_CYCLES consecutive edges.
  - This suppresses the ripple intermediates of the counter: 2→0→4 and 7→4→0.
  - A stability counter resets whenever `sync2` changes.
- Not defined:
  - Every `sync2` change is an event.
  - Ripple intermediates are checked as real codes and cause errors when sampled.

## Test plan
- Reset, then `code_i` = 0, 2, 4, 7, 0, each held 8 cycles, LOCK_CNT=4 → `locked_o` rises when 0 is accepted at the 4th transition; `err_o` never pulses; `step_o` steps 0, 1, 2, 3, 0.
- Locked, then `code_i` jumps 2→7 → one `err_o` pulse, `err_cnt_o` = 1, `locked_o` = 0, state CHECK, `exp_code_o` = 0.
- From SEARCH, `code_i` = 5 then 4 → no error on 5; CHECK entered on 4 with `exp_code_o` = 7. Next 3 → error and SEARCH.
- ERR_W=2, five violations, then `clr_i` asserted in the same cycle as a 6th → count 1, 2, 3, 3, 3, then 1.
- Filter on: 2→0 for 1 cycle, then 4 stable → no error, and `code_o` goes 2→4. Filter off, same stimulus → 0 is accepted and flagged as an error.
- `rst_n_i` pulsed low while LOCKED, mid-hold → all outputs reset asynchronously; re-lock after LOCK_CNT legal steps.
